// File: rtl/stmn_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : stmn_frame_gen
// Description : Byte-serial STM-N frame generator with SOH insertion, running
//               B1 parity and FILL substitution on payload underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module stmn_frame_gen #(
   parameter int         N      = 1,
   parameter int         PTR    = 522,
   parameter logic [7:0] J0_VAL = 8'h01,
   parameter logic [7:0] FILL   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_oh,
   output logic        underrun,
   output logic [15:0] frame_cnt
);

   localparam int c_cols  = 270 * N;
   localparam int c_col_w = $clog2(c_cols);

   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_cols - 1);
   localparam logic [c_col_w-1:0] c_col_inc  = c_col_w'(1);
   localparam logic [c_col_w-1:0] c_col_zero = '0;
   localparam logic [c_col_w-1:0] c_oh_cols  = c_col_w'(9 * N);
   localparam logic [c_col_w-1:0] c_a2_start = c_col_w'(3 * N);
   localparam logic [c_col_w-1:0] c_j0_col   = c_col_w'(6 * N);
   localparam logic [c_col_w-1:0] c_ci_end   = c_col_w'(N);
   localparam logic [c_col_w-1:0] c_h2_col   = c_col_w'(3 * N);
   localparam logic [c_col_w-1:0] c_ff_end   = c_col_w'(4 * N);
   localparam logic [3:0]         c_row_last = 4'd8;

   localparam logic [9:0] c_ptr = 10'(PTR);
   localparam logic [7:0] c_a1  = 8'hF6;
   localparam logic [7:0] c_a2  = 8'h28;
   localparam logic [7:0] c_ci  = 8'h93;
   localparam logic [7:0] c_h1  = {4'b0110, 2'b10, c_ptr[9:8]};
   localparam logic [7:0] c_h2  = c_ptr[7:0];

   logic [c_col_w-1:0] r_col;
   logic [3:0]         r_row;
   logic [7:0]         r_acc;
   logic [7:0]         r_b1;
   logic [15:0]        r_frame_cnt;
   logic [7:0]         r_out_data;
   logic               r_out_valid;
   logic               r_out_sof;
   logic               r_out_oh;
   logic               r_underrun;

   logic               w_payload;
   logic               w_first;
   logic               w_last;
   logic               w_col_wrap;
   logic [7:0]         w_oh_byte;
   logic [7:0]         w_byte;
   logic [7:0]         w_acc_next;

   assign w_payload  = (r_col >= c_oh_cols);
   assign w_first    = (r_row == 4'd0) && (r_col == c_col_zero);
   assign w_col_wrap = (r_col == c_col_last);
   assign w_last     = (r_row == c_row_last) && w_col_wrap;

   // Ready is purely positional so upstream can present data without a bubble.
   assign in_ready = en & ~rst & w_payload;

   always_comb begin
      w_oh_byte = 8'h00;
      case (r_row)
         4'd0: begin
            if (r_col < c_a2_start) begin
               w_oh_byte = c_a1;
            end else if (r_col < c_j0_col) begin
               w_oh_byte = c_a2;
            end else if (r_col == c_j0_col) begin
               w_oh_byte = J0_VAL;
            end
         end
         4'd1: begin
            if (r_col == c_col_zero) begin
               w_oh_byte = r_b1;
            end
         end
         4'd3: begin
            if (r_col == c_col_zero) begin
               w_oh_byte = c_h1;
            end else if (r_col < c_ci_end) begin
               w_oh_byte = c_ci;
            end else if (r_col == c_h2_col) begin
               w_oh_byte = c_h2;
            end else if ((r_col > c_h2_col) && (r_col < c_ff_end)) begin
               w_oh_byte = 8'hFF;
            end
         end
         default: begin
            w_oh_byte = 8'h00;
         end
      endcase
   end

   always_comb begin
      w_byte = w_oh_byte;
      if (w_payload) begin
         w_byte = in_valid ? in_data : FILL;
      end
   end

   // B1 covers every emitted byte, the B1 slot itself included.
   assign w_acc_next = r_acc ^ w_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= 4'd0;
         r_acc       <= 8'h00;
         r_b1        <= 8'h00;
         r_frame_cnt <= 16'd0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_oh    <= 1'b0;
         r_underrun  <= 1'b0;
      end else if (en) begin
         r_out_data  <= w_byte;
         r_out_valid <= 1'b1;
         r_out_sof   <= w_first;
         r_out_oh    <= ~w_payload;
         r_underrun  <= w_payload & ~in_valid;
         if (w_last) begin
            r_b1        <= w_acc_next;
            r_acc       <= 8'h00;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end else begin
            r_acc <= w_acc_next;
         end
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == c_row_last) ? 4'd0 : r_row + 4'd1;
         end else begin
            r_col <= r_col + c_col_inc;
         end
      end else begin
         // Paused: only the valid strobe drops, the rest holds for the sink.
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_sof   = r_out_sof;
   assign out_oh    = r_out_oh;
   assign underrun  = r_underrun;
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stmn_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stmn_frame_gen
// Description : Self-checking bench for stmn_frame_gen (N=1 and N=4 instances).
// Revision    : 1.1 - inline comparisons
// ============================================================================
module tb_stmn_frame_gen;
    localparam int COLS  = 270;
    localparam int FRAME = 2430;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, in_valid, in_ready;
    logic [7:0]  in_data, out_data;
    logic        out_valid, out_sof, out_oh, underrun;
    logic [15:0] frame_cnt;

    logic        rst4, en4, in_valid4, in_ready4;
    logic [7:0]  in_data4, out_data4;
    logic        out_valid4, out_sof4, out_oh4, underrun4;
    logic [15:0] frame_cnt4;

    stmn_frame_gen #(.N(1), .PTR(522), .J0_VAL(8'h01), .FILL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_sof(out_sof), .out_oh(out_oh), .underrun(underrun), .frame_cnt(frame_cnt)
    );

    stmn_frame_gen #(.N(4), .PTR(522), .J0_VAL(8'h01), .FILL(8'h00)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
        .out_sof(out_sof4), .out_oh(out_oh4), .underrun(underrun4), .frame_cnt(frame_cnt4)
    );

    int n_err = 0;
    int n_chk = 0;

    int          m_pos  = 0;
    int          m_fidx = 0;
    logic [7:0]  m_acc  = 8'h00;
    logic [7:0]  m_b1   = 8'h00;
    logic [15:0] m_fcnt = 16'd0;
    logic [7:0]  e_data = 8'h00;
    logic        e_valid = 1'b0, e_sof = 1'b0, e_oh = 1'b0, e_un = 1'b0;

    int          cyc = 0;
    int          g_slot, g_fidx;
    logic [7:0]  g_din;
    int          xfer[0:7];
    logic [7:0]  sb_xor[0:7];
    logic [7:0]  b1_cap[0:7];
    logic [15:0] fend_cnt[0:7];
    int          sof_q[$];

    logic [7:0]  hdr[0:6];
    int          un_cnt, p0, p2;
    logic        paused;

    int          cyc4, sofs4, t0, t1, k4;
    logic        done4;
    logic [7:0]  a4[0:23];
    logic [7:0]  r3[0:15];

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_oh(input int r, input int c, input logic [7:0] b1);
        if (r == 0 && c < 3)  return 8'hF6;
        if (r == 0 && c < 6)  return 8'h28;
        if (r == 0 && c == 6) return 8'h01;
        if (r == 1 && c == 0) return b1;
        if (r == 3 && c == 0) return 8'h6A;
        if (r == 3 && c == 3) return 8'h0A;
        return 8'h00;
    endfunction

    task automatic step(input logic r, input logic e, input logic v);
        logic [7:0] d, b;
        int row, col;
        logic exp_rdy;
        d = 8'($urandom);
        rst = r; en = e; in_valid = v; in_data = d;
        g_din = d;
        #1;
        row = m_pos / COLS;
        col = m_pos % COLS;
        exp_rdy = e & ~r & (col >= 9);
        n_chk++; if (in_ready !== exp_rdy) fail("in_ready", in_ready, exp_rdy);
        g_slot = -1;
        g_fidx = m_fidx;
        if (r) begin
            if (m_pos != 0) m_fidx++;
            m_pos = 0; m_acc = 8'h00; m_b1 = 8'h00; m_fcnt = 16'd0;
            e_data = 8'h00; e_valid = 1'b0; e_sof = 1'b0; e_oh = 1'b0; e_un = 1'b0;
        end else if (e) begin
            if (col < 9) b = exp_oh(row, col, m_b1);
            else         b = v ? d : 8'h00;
            if (in_ready && v && m_fidx < 8) xfer[m_fidx]++;
            if (m_fidx < 8) sb_xor[m_fidx] ^= b;
            e_data = b; e_valid = 1'b1; e_sof = (m_pos == 0);
            e_oh = (col < 9); e_un = (col >= 9) && !v;
            m_acc ^= b;
            g_slot = m_pos;
            if (m_pos == FRAME - 1) begin
                m_b1 = m_acc; m_acc = 8'h00; m_fcnt++; m_pos = 0; m_fidx++;
            end else begin
                m_pos++;
            end
        end else begin
            e_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        n_chk++; if (out_data !== e_data)   fail("out_data", out_data, e_data);
        n_chk++; if (out_valid !== e_valid) fail("out_valid", out_valid, e_valid);
        n_chk++; if (out_sof !== e_sof)     fail("out_sof", out_sof, e_sof);
        n_chk++; if (out_oh !== e_oh)       fail("out_oh", out_oh, e_oh);
        n_chk++; if (underrun !== e_un)     fail("underrun", underrun, e_un);
        n_chk++; if (frame_cnt !== m_fcnt)  fail("frame_cnt", frame_cnt, m_fcnt);
        if (out_valid === 1'b1 && out_sof === 1'b1) sof_q.push_back(cyc);
        if (g_slot == COLS && g_fidx < 8) b1_cap[g_fidx] = out_data;
        if (g_slot == FRAME - 1 && g_fidx < 8) fend_cnt[g_fidx] = frame_cnt;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            xfer[i] = 0; sb_xor[i] = 8'h00; b1_cap[i] = 8'hxx; fend_cnt[i] = 16'hxxxx;
        end
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        rst4 = 1'b1; en4 = 1'b0; in_valid4 = 1'b1; in_data4 = 8'h00;

        repeat (3) step(1'b1, 1'b0, 1'b0);
        n_chk++; if (frame_cnt !== 16'd0) fail("rst_fcnt", frame_cnt, 16'd0);
        n_chk++; if (out_valid !== 1'b0)  fail("rst_valid", out_valid, 1'b0);

        step(1'b0, 1'b1, 1'b1);
        n_chk++; if (out_sof !== 1'b1) fail("first_sof", out_sof, 1'b1);
        hdr[0] = out_data;
        for (int i = 1; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b1);
            hdr[i] = out_data;
        end
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (hdr[i] !== ((i < 3) ? 8'hF6 : ((i < 6) ? 8'h28 : 8'h01)))
                fail("hdr_byte", hdr[i], (i < 3) ? 8'hF6 : ((i < 6) ? 8'h28 : 8'h01));
        end
        for (int i = 0; i < FRAME && m_fidx == 0; i++) step(1'b0, 1'b1, 1'b1);
        n_chk++; if (xfer[0] !== 2349)      fail("xfer_f0", xfer[0], 2349);
        n_chk++; if (fend_cnt[0] !== 16'd1) fail("fcnt_f0", fend_cnt[0], 16'd1);
        n_chk++; if (b1_cap[0] !== 8'h00)   fail("b1_f0", b1_cap[0], 8'h00);

        un_cnt = 0;
        for (int i = 0; i < FRAME && m_fidx == 1; i++) begin
            step(1'b0, 1'b1, !(m_pos >= 640 && m_pos < 645));
            if (g_slot >= 640 && g_slot < 645) begin
                if (underrun === 1'b1) un_cnt++;
                n_chk++; if (out_data !== 8'h00) fail("un_data", out_data, 8'h00);
            end
            if (g_slot == 645) begin
                n_chk++; if (out_data !== g_din) fail("after_un", out_data, g_din);
            end
        end
        n_chk++; if (un_cnt !== 5)             fail("un_pulses", un_cnt, 5);
        n_chk++; if (xfer[1] !== 2344)         fail("xfer_f1", xfer[1], 2344);
        n_chk++; if (b1_cap[1] !== sb_xor[0])  fail("b1_f1", b1_cap[1], sb_xor[0]);
        n_chk++; if (fend_cnt[1] !== 16'd2)    fail("fcnt_f1", fend_cnt[1], 16'd2);

        paused = 1'b0;
        for (int i = 0; i < FRAME + 20 && m_fidx == 2; i++) begin
            if (m_pos == 1130 && !paused) begin
                paused = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    step(1'b0, 1'b0, 1'b1);
                    n_chk++; if (out_valid !== 1'b0) fail("pause_valid", out_valid, 1'b0);
                    n_chk++; if (in_ready !== 1'b0)  fail("pause_rdy", in_ready, 1'b0);
                end
            end
            step(1'b0, 1'b1, ($urandom_range(0, 7) != 0));
        end
        n_chk++; if (b1_cap[2] !== sb_xor[1]) fail("b1_f2", b1_cap[2], sb_xor[1]);

        for (int i = 0; i < FRAME && m_pos != 1370; i++) step(1'b0, 1'b1, 1'b1);
        n_chk++; if (sof_q.size() !== 4) fail("sof_count", sof_q.size(), 4);
        p0 = (sof_q.size() >= 4) ? sof_q[1] - sof_q[0] : 0;
        p2 = (sof_q.size() >= 4) ? sof_q[3] - sof_q[2] : 0;
        n_chk++; if (p0 !== 2430) fail("period_f0", p0, 2430);
        n_chk++; if (p2 !== 2440) fail("period_f2", p2, 2440);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        n_chk++; if (out_data !== 8'h00)   fail("mrst_data", out_data, 8'h00);
        n_chk++; if (out_valid !== 1'b0)   fail("mrst_valid", out_valid, 1'b0);
        n_chk++; if (out_sof !== 1'b0)     fail("mrst_sof", out_sof, 1'b0);
        n_chk++; if (out_oh !== 1'b0)      fail("mrst_oh", out_oh, 1'b0);
        n_chk++; if (underrun !== 1'b0)    fail("mrst_un", underrun, 1'b0);
        n_chk++; if (frame_cnt !== 16'd0)  fail("mrst_fcnt", frame_cnt, 16'd0);
        step(1'b0, 1'b1, 1'b1);
        n_chk++; if (out_data !== 8'hF6)   fail("post_rst_a1", out_data, 8'hF6);
        n_chk++; if (out_sof !== 1'b1)     fail("post_rst_sof", out_sof, 1'b1);
        n_chk++; if (frame_cnt !== 16'd0)  fail("post_rst_fcnt", frame_cnt, 16'd0);
        for (int i = 0; i < 300 && g_slot != COLS; i++) step(1'b0, 1'b1, 1'b1);
        n_chk++; if (b1_cap[m_fidx] !== 8'h00) fail("post_rst_b1", b1_cap[m_fidx], 8'h00);

        en = 1'b0; rst = 1'b0;
        rst4 = 1'b1; en4 = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (out_valid4 !== 1'b0) fail("n4_rst_valid", out_valid4, 1'b0);
        rst4 = 1'b0;
        cyc4 = 0; sofs4 = 0; t0 = 0; t1 = 0; k4 = 0; done4 = 1'b0;
        for (int i = 0; i < 9800 && !done4; i++) begin
            in_data4 = 8'($urandom);
            @(posedge clk); #1;
            cyc4++;
            if (out_valid4 === 1'b1) begin
                if (out_sof4 === 1'b1) begin
                    sofs4++;
                    k4 = 0;
                    if (sofs4 == 1) t0 = cyc4;
                    else begin t1 = cyc4; done4 = 1'b1; end
                end
                if (sofs4 == 1) begin
                    if (k4 < 24) a4[k4] = out_data4;
                    if (k4 >= 3240 && k4 < 3256) r3[k4 - 3240] = out_data4;
                    k4++;
                end
            end
        end
        n_chk++; if ((t1 - t0) !== 9720)    fail("n4_period", t1 - t0, 9720);
        n_chk++; if (frame_cnt4 !== 16'd1)  fail("n4_fcnt", frame_cnt4, 16'd1);
        for (int i = 0; i < 24; i++) begin
            n_chk++;
            if (a4[i] !== ((i < 12) ? 8'hF6 : 8'h28))
                fail("n4_a1a2", a4[i], (i < 12) ? 8'hF6 : 8'h28);
        end
        n_chk++; if (r3[0] !== 8'h6A) fail("n4_h1", r3[0], 8'h6A);
        for (int i = 1; i < 4; i++) begin
            n_chk++; if (r3[i] !== 8'h93) fail("n4_ci", r3[i], 8'h93);
        end
        for (int i = 4; i < 12; i++) begin
            n_chk++; if (r3[i] !== 8'h00) fail("n4_zero", r3[i], 8'h00);
        end
        n_chk++; if (r3[12] !== 8'h0A) fail("n4_h2", r3[12], 8'h0A);
        for (int i = 13; i < 16; i++) begin
            n_chk++; if (r3[i] !== 8'hFF) fail("n4_ff", r3[i], 8'hFF);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
